// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner:
// state encoding, geometry and key-code helpers.
package keypad_pkg;

   localparam int KEY_W = 4;
   localparam int ROWS  = 4;
   localparam int COLS  = 3;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } state_t;

   // Lowest asserted column wins when several keys share a row
   function automatic logic [1:0] low_col(input logic [COLS-1:0] pat);
      if (pat[0]) return 2'd0;
      if (pat[1]) return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [KEY_W-1:0] key_code_f(
      input logic [1:0] row,
      input logic [1:0] col
   );
      return KEY_W'(row) * KEY_W'(COLS) + KEY_W'(col);
   endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through FIFO for key codes.
// A full FIFO still takes a push when the head is popped in the same cycle.
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic [W-1:0]  r_last;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_data  = o_empty ? r_last : r_mem[r_rd];

   // Storage array, written at the tail pointer
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   // Pointers, occupancy and the last popped code shown while empty
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_cnt  <= '0;
         r_last <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) begin
            r_rd   <= r_rd + AW'(1);
            r_last <= r_mem[r_rd];
         end
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

// File: rtl/keypad_matrix_ctrl.sv
// 4x3 keypad scanner: row strobing, column sync, press/release
// debounce and a one-code-per-press FIFO towards the consumer.
module keypad_matrix_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_CNT    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [COLS-1:0]  col_in,
   output logic [ROWS-1:0]  row_out,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEB_CNT + 1);

   state_t          r_state;
   state_t          w_state_n;
   logic [COLS-1:0] r_sync1;
   logic [COLS-1:0] r_sync2;
   logic [CW-1:0]   r_tcnt;
   logic [1:0]      r_row;
   logic [COLS-1:0] r_pat;
   logic [COLS-1:0] w_pat_n;
   logic [DW-1:0]   r_deb;
   logic [DW-1:0]   w_deb_n;
   logic [DW-1:0]   r_rel;
   logic [DW-1:0]   w_rel_n;
   logic            r_ovf;
   logic            w_tick;
   logic            w_adv;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic            w_drop;
   logic [KEY_W-1:0] w_code;

   assign w_tick    = (r_tcnt == CW'(SCAN_DIV - 1));
   assign row_out   = ROWS'(1) << r_row;
   assign key_valid = ~w_empty;
   assign w_pop     = key_valid & key_ready;
   assign w_drop    = w_push & w_full & ~w_pop;
   assign overflow  = r_ovf;
   assign w_code    = key_code_f(r_row, low_col(w_pat_n));

   // Two-flop synchronizer for the asynchronous column lines
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= col_in;
         r_sync2 <= r_sync1;
      end
   end

   // Scan-period counter and row rotation; rows only move on a tick
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tcnt <= '0;
         r_row  <= '0;
      end else begin
         r_tcnt <= w_tick ? '0 : r_tcnt + CW'(1);
         if (w_adv) r_row <= r_row + 2'd1;
      end
   end

   // FSM state and debounce counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SCAN;
         r_pat   <= '0;
         r_deb   <= '0;
         r_rel   <= '0;
      end else begin
         r_state <= w_state_n;
         r_pat   <= w_pat_n;
         r_deb   <= w_deb_n;
         r_rel   <= w_rel_n;
      end
   end

   // Next state, row advance and push decision, evaluated per tick
   always_comb begin
      w_state_n = r_state;
      w_pat_n   = r_pat;
      w_deb_n   = r_deb;
      w_rel_n   = r_rel;
      w_adv     = 1'b0;
      w_push    = 1'b0;
      if (w_tick) begin
         unique case (r_state)
            SCAN: begin
               if (r_sync2 != '0) begin
                  w_pat_n = r_sync2;
                  if (DEB_CNT == 1) begin
                     w_push    = 1'b1;
                     w_state_n = PRESSED;
                  end else begin
                     w_deb_n   = DW'(1);
                     w_state_n = DEBOUNCE;
                  end
               end else begin
                  w_adv = 1'b1;
               end
            end
            DEBOUNCE: begin
               if (r_sync2 == r_pat) begin
                  if (r_deb == DW'(DEB_CNT - 1)) begin
                     w_push    = 1'b1;
                     w_state_n = PRESSED;
                  end else begin
                     w_deb_n = r_deb + DW'(1);
                  end
               end else begin
                  w_state_n = SCAN;
                  w_adv     = 1'b1;
               end
            end
            PRESSED: begin
               if (r_sync2 == '0) begin
                  if (DEB_CNT == 1) begin
                     w_state_n = SCAN;
                     w_adv     = 1'b1;
                  end else begin
                     w_rel_n   = DW'(1);
                     w_state_n = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (r_sync2 == '0) begin
                  if (r_rel == DW'(DEB_CNT - 1)) begin
                     w_state_n = SCAN;
                     w_adv     = 1'b1;
                  end else begin
                     w_rel_n = r_rel + DW'(1);
                  end
               end else begin
                  w_rel_n   = '0;
                  w_state_n = PRESSED;
               end
            end
            default: w_state_n = SCAN;
         endcase
      end
   end

   // Sticky overflow; a fresh drop wins over a clear
   always_ff @(posedge clk) begin
      if (rst)          r_ovf <= 1'b0;
      else if (w_drop)  r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
   end

   key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (KEY_W)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_push  (w_push),
      .i_data  (w_code),
      .i_pop   (w_pop),
      .o_data  (key_code),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule
